cic_interp_lite: RTL
====================

CIC_INTERP_LITE -- requirements
Module: cic_interp_lite

Interface
REQ-001 Parameter BITS, default 8: signed input sample width.
REQ-002 Parameter INTERP, default 64: interpolation factor, power of two, 2..65536.
REQ-003 Parameter WIDTH, default 26: internal register width; SHALL be at least BITS + 3*log2(INTERP).
REQ-004 Parameter OUT_SHIFT, default 4: arithmetic right shift from the last integrator to x_out.
REQ-005 CLK  in  1: single system clock; all state SHALL change on posedge CLK, except under reset.
REQ-006 RSTb  in  1: reset, asynchronous, active-low.
REQ-007 tick  in  1: output-rate strobe, one CLK wide, any spacing of at least 1 cycle.
REQ-008 x_in  in  BITS signed: low-rate input sample.
REQ-009 in_valid  in  1: x_in valid.
REQ-010 in_ready  out  1: input buffer empty; a transfer occurs when in_valid and in_ready are both high.
REQ-011 clr_underrun  in  1: clears the underrun flag.
REQ-012 x_out  out  16 signed: high-rate output sample.
REQ-013 out_tick  out  1: one-cycle pulse when x_out updates.
REQ-014 underrun  out  1: sticky flag for a missed input sample.

Function
REQ-015 Structure: 3 comb stages at low rate, zero-stuffing by INTERP, then 3 integrator stages at tick rate; all arithmetic is WIDTH-bit two's complement with wrap-around; x_in is sign-extended.
REQ-016 Phase counter: 0..INTERP-1, +1 per tick, wraps from INTERP-1 to 0; no change without tick.
REQ-017 Input buffer, one entry: on a transfer, x_in is stored and in_ready goes low the next cycle.
REQ-018 Phase-0 tick, buffer full: buffered sample s is consumed, and in_ready is high the next cycle.
REQ-019 Phase-0 tick, buffer empty: s = 0 is used and underrun is set; a transfer in that same cycle is buffered for the next phase-0 tick, not used now.
REQ-020 Combs on phase-0 ticks only: c1 = s - d1, c2 = c1 - d2, c3 = c2 - d3, computed combinationally; d1<=s, d2<=c1, d3<=c2.
REQ-021 Upsample register u, on every tick: u <= c3 when phase = 0, else 0.
REQ-022 Integrators, on every tick: i1<=i1+u, i2<=i2+i1, i3<=i3+i2, each using pre-tick values.
REQ-023 Output, on every tick: x_out <= (i3 as held before that tick) >>> OUT_SHIFT, reduced to 16 bits per REQ-030/031.
REQ-024 out_tick is high exactly the cycle after each tick; DC gain is INTERP^2 / 2^OUT_SHIFT.
REQ-025 Latency: a nonzero s consumed on tick T0 first appears in x_out on tick T0+4.
REQ-026 underrun is set per REQ-019 and cleared by clr_underrun; set wins when both occur in the same cycle.

Reset
REQ-027 RSTb low SHALL immediately clear phase, buffer, d1-d3, u, i1-i3, x_out, out_tick and underrun to 0, with in_ready = 1.
REQ-028 Reset asserted mid-operation SHALL discard any buffered sample; the first tick after release has phase 0.
REQ-029 tick and in_valid during reset SHALL be ignored.

Configuration
REQ-030 With CIC_INTERP_SAT_EN defined, a shifted value outside [-32768, 32767] SHALL clamp to -32768 or 32767.
REQ-031 Without CIC_INTERP_SAT_EN, x_out SHALL be the low 16 bits of the shifted value (wrap).

Verification
REQ-032 Constant x_in = 1 supplied every phase-0 tick, default params -> after settling (at most 3*INTERP ticks), x_out = 256 on every out_tick; underrun stays 0.
REQ-033 Single x_in = 16, then zeros, consumed at tick T0 -> x_out changes first at tick T0+4, with value 1; the response returns to 0 after at most 3*INTERP+4 ticks.
REQ-034 in_valid held low across a phase-0 tick -> underrun = 1 and u = 0 for that frame; clr_underrun with no new underrun -> underrun = 0 the next cycle.
REQ-035 in_valid high for 2 consecutive cycles between phase-0 ticks -> only the first sample is transferred; in_ready stays low until the next phase-0 tick.
REQ-036 Constant x_in = 127 with OUT_SHIFT = 0 -> with CIC_INTERP_SAT_EN, x_out = 32767; without it, x_out = low 16 bits of 127*4096, i.e. -4096.
REQ-037 RSTb pulsed low mid-frame with the buffer full -> all outputs 0 and in_ready = 1 immediately; the first post-reset tick is phase 0.

Source files
------------

// File: rtl/cic_interp_lite.sv
// 3-stage CIC interpolator (low-rate combs, tick-rate integrators); a sample consumed on tick T reaches x_out on tick T+4.
// One-entry input buffer, in_ready low while full; CIC_INTERP_SAT_EN selects 16-bit output saturation instead of wrap.
module cic_interp_lite #(
   parameter int BITS      = 8,
   parameter int INTERP    = 64,
   parameter int WIDTH     = 26,
   parameter int OUT_SHIFT = 4
) (
   input  logic                   CLK,
   input  logic                   RSTb,
   input  logic                   tick,
   input  logic signed [BITS-1:0] x_in,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic                   clr_underrun,
   output logic signed [15:0]     x_out,
   output logic                   out_tick,
   output logic                   underrun
);

   localparam int PW = $clog2(INTERP);
   localparam int EW = (WIDTH > 17) ? WIDTH : 17;

   logic [PW-1:0]           r_phase;
   logic                    r_full;
   logic signed [BITS-1:0]  r_buf;
   logic signed [WIDTH-1:0] r_d1, r_d2, r_d3, r_u, r_i1, r_i2, r_i3;

   logic                    w_xfer, w_p0;
   logic signed [WIDTH-1:0] w_s, w_c1, w_c2, w_c3, w_shift;
   logic signed [EW-1:0]    w_ext;
   logic signed [15:0]      w_out;

   assign in_ready = !r_full;
   assign w_xfer   = in_valid && !r_full;
   assign w_p0     = tick && (r_phase == '0);

   // An empty buffer on a phase-0 tick feeds a zero sample into the combs.
   assign w_s  = r_full ? WIDTH'(r_buf) : '0;
   assign w_c1 = w_s - r_d1;
   assign w_c2 = w_c1 - r_d2;
   assign w_c3 = w_c2 - r_d3;

   assign w_shift = r_i3 >>> OUT_SHIFT;
   assign w_ext   = EW'(w_shift);

`ifdef CIC_INTERP_SAT_EN
   localparam logic signed [EW-1:0] SAT_HI = EW'(32767);
   localparam logic signed [EW-1:0] SAT_LO = EW'(-32768);

   always_comb begin
      w_out = w_ext[15:0];
      if (w_ext > SAT_HI)
         w_out = 16'sh7FFF;
      else if (w_ext < SAT_LO)
         w_out = 16'sh8000;
   end
`else
   logic w_unused_hi;
   assign w_unused_hi = ^w_ext[EW-1:16];
   assign w_out       = w_ext[15:0];
`endif

   always_ff @(posedge CLK or negedge RSTb) begin
      if (!RSTb) begin
         r_phase  <= '0;
         r_full   <= 1'b0;
         r_buf    <= '0;
         r_d1     <= '0;
         r_d2     <= '0;
         r_d3     <= '0;
         r_u      <= '0;
         r_i1     <= '0;
         r_i2     <= '0;
         r_i3     <= '0;
         x_out    <= '0;
         out_tick <= 1'b0;
         underrun <= 1'b0;
      end else begin
         out_tick <= tick;

         // A transfer landing on an empty-buffer phase-0 tick is kept for the next frame.
         if (w_p0 && r_full)
            r_full <= 1'b0;
         else if (w_xfer) begin
            r_full <= 1'b1;
            r_buf  <= x_in;
         end

         if (w_p0 && !r_full)
            underrun <= 1'b1;
         else if (clr_underrun)
            underrun <= 1'b0;

         if (w_p0) begin
            r_d1 <= w_s;
            r_d2 <= w_c1;
            r_d3 <= w_c2;
         end

         if (tick) begin
            r_phase <= r_phase + 1'b1;
            r_u     <= w_p0 ? w_c3 : '0;
            r_i1    <= r_i1 + r_u;
            r_i2    <= r_i2 + r_i1;
            r_i3    <= r_i3 + r_i2;
            x_out   <= w_out;
         end
      end
   end

endmodule
